mp_sequencer: RTL and testbench

- Multi-cycle control sequencer for the 8-bit micro-processor datapath: PC, instruction memory, register file and ALU.
- Replaces single-cycle decode with a FETCH/DECODE/EXEC/WB state machine.
- Latches the instruction and ALU flags, and drives PC increment/load, memory read, register-file read/write and ALU control.
- Supports ALU ops, unconditional and flag-conditional jumps, NOP and HALT.

---
 rtl/mp_pkg.sv | 50 +++++
 rtl/mp_decode.sv | 26 ++
 rtl/mp_sequencer.sv | 147 ++++++++++++++
 tb/tb_mp_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mp_pkg.sv
// Shared definitions for the multi-cycle sequencer: opcodes, FSM states,
// decoded instruction classes and instruction field positions.
package mp_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ALU  = 4'h1;
    localparam logic [3:0] OP_JMP  = 4'h2;
    localparam logic [3:0] OP_JZ   = 4'h3;
    localparam logic [3:0] OP_JC   = 4'h4;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OPC_W    = 4;
    localparam int OPC_LSB  = 12;
    localparam int DST_LSB  = 9;
    localparam int SRC1_LSB = 6;
    localparam int SRC2_LSB = 3;
    localparam int FUNC_LSB = 0;
    localparam int TGT_LSB  = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        C_NOP,
        C_ALU,
        C_JMP,
        C_JZ,
        C_JC,
        C_HALT
    } op_class_e;

    // Unassigned opcodes fold into C_NOP so the FSM never sees an illegal class.
    function automatic op_class_e classify(input logic [OPC_W-1:0] opc);
        case (opc)
            OP_ALU:  return C_ALU;
            OP_JMP:  return C_JMP;
            OP_JZ:   return C_JZ;
            OP_JC:   return C_JC;
            OP_HALT: return C_HALT;
            default: return C_NOP;
        endcase
    endfunction

endpackage

// File: rtl/mp_decode.sv
// Combinational instruction decoder: splits the latched instruction word
// into its opcode class, register fields, ALU function and jump target.
module mp_decode
    import mp_pkg::*;
#(
    parameter int PC_W = 8,
    parameter int IR_W = 16,
    parameter int RA_W = 3
) (
    input  logic [IR_W-1:0] ir,
    output op_class_e       op_class,
    output logic [RA_W-1:0] dst,
    output logic [RA_W-1:0] src1,
    output logic [RA_W-1:0] src2,
    output logic [RA_W-1:0] func,
    output logic [PC_W-1:0] target
);

    assign op_class = classify(ir[OPC_LSB +: OPC_W]);
    assign dst      = ir[DST_LSB  +: RA_W];
    assign src1     = ir[SRC1_LSB +: RA_W];
    assign src2     = ir[SRC2_LSB +: RA_W];
    assign func     = ir[FUNC_LSB +: RA_W];
    assign target   = ir[TGT_LSB  +: PC_W];

endmodule

// File: rtl/mp_sequencer.sv
// FETCH/DECODE/EXEC/WB control sequencer for the 8-bit datapath. Every
// output is a decode of registered state, so no input reaches an output.
module mp_sequencer
    import mp_pkg::*;
#(
    parameter int PC_W = 8,
    parameter int IR_W = 16,
    parameter int RA_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [IR_W-1:0] ir_data,
    input  logic            cy,
    input  logic            zero,
    output logic            mrd,
    output logic            pc_inc,
    output logic            pc_load,
    output logic [PC_W-1:0] pc_target,
    output logic [RA_W-1:0] addr1,
    output logic [RA_W-1:0] addr2,
    output logic [RA_W-1:0] wr_addr,
    output logic            rd,
    output logic            wr,
    output logic [RA_W-1:0] alu_ctrl,
    output logic            busy,
    output logic            halted
);

    state_e          state_q, state_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic            cy_q, cy_d;
    logic            z_q, z_d;

    op_class_e       op_class;
    logic [RA_W-1:0] dst, src1, src2, func;
    logic [PC_W-1:0] target;
    logic            take_jump;

    mp_decode #(
        .PC_W (PC_W),
        .IR_W (IR_W),
        .RA_W (RA_W)
    ) u_decode (
        .ir       (ir_q),
        .op_class (op_class),
        .dst      (dst),
        .src1     (src1),
        .src2     (src2),
        .func     (func),
        .target   (target)
    );

    // NOTE: state uses non-blocking assignments so every flop updates from
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            cy_q    <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cy_q    <= cy_d;
            z_q     <= z_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_d   = state_q;
        ir_d      = ir_q;
        cy_d      = cy_q;
        z_d       = z_q;
        mrd       = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        pc_target = '0;
        addr1     = '0;
        addr2     = '0;
        wr_addr   = '0;
        rd        = 1'b0;
        wr        = 1'b0;
        alu_ctrl  = '0;
        halted    = 1'b0;
        take_jump = 1'b0;
        busy      = (state_q != S_IDLE) && (state_q != S_HALT);

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                mrd     = 1'b1;
                ir_d    = ir_data;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                addr1   = src1;
                addr2   = src2;
                rd      = 1'b1;
                state_d = (op_class == C_HALT) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (op_class)
                    C_ALU: begin
                        addr1    = src1;
                        addr2    = src2;
                        rd       = 1'b1;
                        alu_ctrl = func;
                        cy_d     = cy;
                        z_d      = zero;
                        state_d  = S_WB;
                    end
                    C_JMP, C_JZ, C_JC: begin
                        // Conditional jumps test flags from the last ALU op.
                        if (op_class == C_JMP)     take_jump = 1'b1;
                        else if (op_class == C_JZ) take_jump = z_q;
                        else                       take_jump = cy_q;
                        pc_target = target;
                        pc_load   = take_jump;
                        pc_inc    = ~take_jump;
                    end
                    default: pc_inc = 1'b1;
                endcase
            end
            S_WB: begin
                addr1    = src1;
                addr2    = src2;
                rd       = 1'b1;
                alu_ctrl = func;
                wr       = 1'b1;
                wr_addr  = dst;
                pc_inc   = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mp_sequencer.sv
// Directed bench for mp_sequencer: a spec-level model pushes the expected
// per-cycle output vector to a queue, which is popped and compared each cycle.
module tb_mp_sequencer;
    import mp_pkg::*;

    localparam int PC_W = 8;
    localparam int IR_W = 16;
    localparam int RA_W = 3;

    logic            clk = 1'b0;
    logic            rst, start, cy, zero;
    logic [IR_W-1:0] ir_data;
    logic            mrd, pc_inc, pc_load, rd, wr, busy, halted;
    logic [PC_W-1:0] pc_target;
    logic [RA_W-1:0] addr1, addr2, wr_addr, alu_ctrl;

    typedef struct packed {
        logic       mrd;
        logic       pc_inc;
        logic       pc_load;
        logic [7:0] pc_target;
        logic [2:0] addr1;
        logic [2:0] addr2;
        logic [2:0] wr_addr;
        logic       rd;
        logic       wr;
        logic [2:0] alu_ctrl;
        logic       busy;
        logic       halted;
    } out_t;

    out_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    logic m_cy, m_z;
    out_t wb_rec;

    mp_sequencer #(.PC_W(PC_W), .IR_W(IR_W), .RA_W(RA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ir_data   (ir_data),
        .cy        (cy),
        .zero      (zero),
        .mrd       (mrd),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .pc_target (pc_target),
        .addr1     (addr1),
        .addr2     (addr2),
        .wr_addr   (wr_addr),
        .rd        (rd),
        .wr        (wr),
        .alu_ctrl  (alu_ctrl),
        .busy      (busy),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic check_out(input string tag, input out_t exp);
        out_t obs;
        obs.mrd       = mrd;
        obs.pc_inc    = pc_inc;
        obs.pc_load   = pc_load;
        obs.pc_target = pc_target;
        obs.addr1     = addr1;
        obs.addr2     = addr2;
        obs.wr_addr   = wr_addr;
        obs.rd        = rd;
        obs.wr        = wr;
        obs.alu_ctrl  = alu_ctrl;
        obs.busy      = busy;
        obs.halted    = halted;
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected cycle-by-cycle outputs for one instruction, from FETCH onward.
    task automatic push_instr(input logic [15:0] ir);
        out_t       r;
        logic [3:0] opc;
        logic       take;
        opc = ir[15:12];
        r = '0; r.mrd = 1'b1; r.busy = 1'b1;
        exp_q.push_back(r);
        r = '0; r.addr1 = ir[8:6]; r.addr2 = ir[5:3]; r.rd = 1'b1; r.busy = 1'b1;
        exp_q.push_back(r);
        if (opc != 4'hF) begin
            r = '0; r.busy = 1'b1;
            case (opc)
                4'h1: begin
                    r.addr1 = ir[8:6]; r.addr2 = ir[5:3]; r.rd = 1'b1; r.alu_ctrl = ir[2:0];
                    exp_q.push_back(r);
                    r.wr = 1'b1; r.wr_addr = ir[11:9]; r.pc_inc = 1'b1;
                    exp_q.push_back(r);
                end
                4'h2, 4'h3, 4'h4: begin
                    take = (opc == 4'h2) ? 1'b1 : (opc == 4'h3) ? m_z : m_cy;
                    r.pc_target = ir[7:0]; r.pc_load = take; r.pc_inc = ~take;
                    exp_q.push_back(r);
                end
                default: begin
                    r.pc_inc = 1'b1;
                    exp_q.push_back(r);
                end
            endcase
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            @(negedge clk);
            check_out($sformatf("%s[%0d]", tag, n), exp_q.pop_front());
            n++;
        end
    endtask

    task automatic do_instr(input string tag, input logic [15:0] ir, input logic c, input logic z);
        ir_data = ir;
        cy      = c;
        zero    = z;
        push_instr(ir);
        drain(tag);
        if (ir[15:12] == 4'h1) begin
            m_cy = c;
            m_z  = z;
        end
    endtask

    initial begin
        out_t hrec;
        rst = 1'b1; start = 1'b0; ir_data = '0; cy = 1'b0; zero = 1'b0;
        m_cy = 1'b0; m_z = 1'b0;
        #1 check_out("reset", '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.push_back('0);
        drain("idle_no_start");

        start = 1'b1;
        do_instr("alu_z1",   16'h1253, 1'b0, 1'b1);
        do_instr("jz_taken", 16'h302A, 1'b0, 1'b0);
        do_instr("alu_z0",   16'h1253, 1'b0, 1'b0);
        do_instr("jz_not",   16'h302A, 1'b1, 1'b1);
        do_instr("alu_cy1",  16'h1A95, 1'b1, 1'b0);
        do_instr("jc_taken", 16'h4011, 1'b0, 1'b0);
        start = 1'b0;
        do_instr("jmp",      16'h2005, 1'b0, 1'b0);
        do_instr("unknown",  16'h7ABC, 1'b1, 1'b1);
        do_instr("nop",      16'h0000, 1'b0, 1'b0);

        // ALU op with both flags set, then reset asynchronously inside WB.
        ir_data = 16'h1253; cy = 1'b1; zero = 1'b1;
        push_instr(16'h1253);
        wb_rec = exp_q.pop_back();
        drain("alu_pre_rst");
        @(posedge clk);
        #2 check_out("wb_before_rst", wb_rec);
        rst = 1'b1;
        #1 check_out("rst_async", '0);
        check_val("rst_state", 8'(dut.state_q), 8'(S_IDLE));
        check_val("rst_cy_q",  8'(dut.cy_q), 8'h00);
        check_val("rst_z_q",   8'(dut.z_q),  8'h00);
        m_cy = 1'b0; m_z = 1'b0;
        @(negedge clk);
        rst = 1'b0; start = 1'b1;
        do_instr("jz_after_rst", 16'h302A, 1'b1, 1'b1);
        do_instr("jc_after_rst", 16'h4011, 1'b1, 1'b1);

        ir_data = 16'hF000;
        push_instr(16'hF000);
        hrec = '0; hrec.halted = 1'b1;
        exp_q.push_back(hrec);
        drain("halt");
        for (int i = 0; i < 4; i++) begin
            start = ~start;
            @(posedge clk);
            @(negedge clk);
            check_out($sformatf("halt_hold[%0d]", i), hrec);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
